// File: rtl/writeback_queue_pkg.sv
// Shared constants and helpers for the writeback queue and its FIFO.
package writeback_queue_pkg;

    localparam int WB_DEPTH  = 4;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_CNT_W  = $clog2(WB_DEPTH) + 1;
    localparam int NUM_REGS  = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    // An entry is packed as {dest, data}; data occupies the low bits.
    localparam int ENTRY_W        = WB_ADDR_W + WB_DATA_W;
    localparam int ENTRY_DATA_OFF = 0;
    localparam int ENTRY_DEST_OFF = WB_DATA_W;

    // Decoded register bit used to build the pending-write mask.
    function automatic logic [NUM_REGS-1:0] oneHot(input logic [WB_ADDR_W-1:0] dest);
        oneHot = NUM_REGS'(1) << dest;
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Bundle of the ALU/load push ports, the register-file write port and status.
interface writeback_queue_if
    import writeback_queue_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int CNT_W  = WB_CNT_W
);

    logic                aluValid;
    logic                aluReady;
    logic [ADDR_W-1:0]   aluDest;
    logic [DATA_W-1:0]   aluData;
    logic                memValid;
    logic [ADDR_W-1:0]   memDest;
    logic [DATA_W-1:0]   memData;
    logic                wrEn;
    logic [ADDR_W-1:0]   wrAddr;
    logic [DATA_W-1:0]   wrData;
    logic [NUM_REGS-1:0] busyMask;
    logic [CNT_W-1:0]    count;

    // Upstream producers and the register file sit on this side.
    modport master (
        output aluValid, aluDest, aluData, memValid, memDest, memData,
        input  aluReady, wrEn, wrAddr, wrData, busyMask, count
    );

    // The writeback queue itself sits on this side.
    modport slave (
        input  aluValid, aluDest, aluData, memValid, memDest, memData,
        output aluReady, wrEn, wrAddr, wrData, busyMask, count
    );

endinterface

// File: rtl/writeback_queue_fifo.sv
// Two-write / one-read circular buffer. Port 0 is written ahead of port 1
// in the same cycle, so port 0 must carry the older result.
module sync_fifo_2w
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int CNT_W  = $clog2(DEPTH) + 1
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr0En,
    input  logic [ADDR_W-1:0]             i_wr0Dest,
    input  logic [DATA_W-1:0]             i_wr0Data,
    input  logic                          i_wr1En,
    input  logic [ADDR_W-1:0]             i_wr1Dest,
    input  logic [DATA_W-1:0]             i_wr1Data,
    input  logic                          i_rdEn,
    output logic [ADDR_W-1:0]             o_headDest,
    output logic [DATA_W-1:0]             o_headData,
    output logic [CNT_W-1:0]              o_count,
    output logic [DEPTH-1:0]              o_validVec,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_destVec
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_dest [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic              w_pop;
    logic [PTR_W-1:0]  w_slot0;
    logic [PTR_W-1:0]  w_slot1;

    // Port 1 lands right behind port 0, or at the tail when port 0 is idle.
    always_comb begin
        w_pop   = i_rdEn && (r_count != '0);
        w_slot0 = r_tail;
        w_slot1 = r_tail + PTR_W'(i_wr0En);
    end

    // Pointers and occupancy; power-of-two depth makes pointer wrap free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(i_wr0En) + PTR_W'(i_wr1En);
            r_count <= r_count + CNT_W'(i_wr0En) + CNT_W'(i_wr1En) - CNT_W'(w_pop);
        end
    end

    // Per-slot valid bits feed the pending-register mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
            end
            if (i_wr0En) begin
                r_valid[w_slot0] <= 1'b1;
            end
            if (i_wr1En) begin
                r_valid[w_slot1] <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (i_wr0En) begin
            r_dest[w_slot0] <= i_wr0Dest;
            r_data[w_slot0] <= i_wr0Data;
        end
        if (i_wr1En) begin
            r_dest[w_slot1] <= i_wr1Dest;
            r_data[w_slot1] <= i_wr1Data;
        end
    end

    // Expose head entry and the destination of every slot.
    always_comb begin
        o_headDest = r_dest[r_head];
        o_headData = r_data[r_head];
        o_count    = r_count;
        o_validVec = r_valid;
        o_destVec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_destVec[i] = r_dest[i];
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback stage: merges ALU and load results into a FIFO and retires one
// register-file write per cycle, publishing a pending-register mask.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
)(
    input  logic              clk,
    input  logic              rst,
    writeback_queue_if.slave  wb
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic                         w_aluReady;
    logic                         w_aluStore;
    logic                         w_memStore;
    logic                         w_pop;
    logic [ADDR_W-1:0]            w_headDest;
    logic [DATA_W-1:0]            w_headData;
    logic [CNT_W-1:0]             w_count;
    logic [DEPTH-1:0]             w_validVec;
    logic [DEPTH-1:0][ADDR_W-1:0] w_destVec;
    logic [NUM_REGS-1:0]          w_busyMask;

    logic                         r_wrEn;
    logic [ADDR_W-1:0]            r_wrAddr;
    logic [DATA_W-1:0]            r_wrData;

    // Keep one slot free for loads, which cannot be stalled; dest 0 pushes
    // complete their handshake but never reach the queue.
    always_comb begin
        w_aluReady = (w_count <= READY_MAX);
        w_aluStore = wb.aluValid && w_aluReady && (wb.aluDest != REG_ZERO);
        w_memStore = wb.memValid && (wb.memDest != REG_ZERO);
        w_pop      = (w_count != '0);
    end

    // The load goes in port 0 because it belongs to the older instruction.
    sync_fifo_2w #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr0En    (w_memStore),
        .i_wr0Dest  (wb.memDest),
        .i_wr0Data  (wb.memData),
        .i_wr1En    (w_aluStore),
        .i_wr1Dest  (wb.aluDest),
        .i_wr1Data  (wb.aluData),
        .i_rdEn     (w_pop),
        .o_headDest (w_headDest),
        .o_headData (w_headData),
        .o_count    (w_count),
        .o_validVec (w_validVec),
        .o_destVec  (w_destVec)
    );

    // Register the head into the write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
        end else if (w_pop) begin
            r_wrEn   <= 1'b1;
            r_wrAddr <= w_headDest;
            r_wrData <= w_headData;
        end else begin
            r_wrEn   <= 1'b0;
        end
    end

    // Pending mask from state only: queued entries plus the write in flight.
    always_comb begin
        w_busyMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_validVec[i]) begin
                w_busyMask = w_busyMask | oneHot(w_destVec[i]);
            end
        end
        if (r_wrEn) begin
            w_busyMask = w_busyMask | oneHot(r_wrAddr);
        end
    end

    // A load arriving with no free slot would be silently lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wb.memValid && (w_count == FULL_CNT)));
            assert (w_count < FULL_CNT);
        end
    end

    // Drive the interface outputs.
    always_comb begin
        wb.aluReady = w_aluReady;
        wb.wrEn     = r_wrEn;
        wb.wrAddr   = r_wrAddr;
        wb.wrData   = r_wrData;
        wb.busyMask = w_busyMask;
        wb.count    = w_count;
    end

endmodule
